// File: rtl/seq_adder_pkg.sv
// Shared types for the multi-cycle chunked ripple adder.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder made of full-adder cells.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/seq_ripple_adder.sv
// Sequential adder/subtractor: one CHUNK-bit slice per cycle through a single
// chunk_adder, result and flags held until the consumer takes them.
module seq_ripple_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output state_t           dbg_state
);

  localparam int NCHUNK = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int IW     = idx_width(NCHUNK);
  localparam int MSB    = WIDTH - 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $fatal(1, "seq_ripple_adder: CHUNK must be >= 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $fatal(1, "seq_ripple_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [IW-1:0]    k;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [31:0]      base;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] c_sum;
  logic             c_out;
  logic [WIDTH-1:0] sum_nxt;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in HOLD, and
  // nothing offered outside those states is looked at.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign dbg_state = state;

  assign base = 32'(k) * 32'(CHUNK);
  assign a_c  = a_r[base +: CHUNK];
  assign b_c  = b_r[base +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_c),
    .b    (b_c),
    .cin  (carry),
    .sum  (c_sum),
    .cout (c_out)
  );

  always_comb begin
    sum_nxt = sum;
    sum_nxt[base +: CHUNK] = c_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + 1, so the inversion and the +1 happen here.
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub | cin;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_nxt;
          carry <= c_out;
          if (k == LAST) begin
            k     <= '0;
            cout  <= c_out;
            ovf   <= (a_r[MSB] == b_r[MSB]) && (sum_nxt[MSB] != a_r[MSB]);
            zero  <= (sum_nxt == '0);
            state <= HOLD;
          end else begin
            k <= k + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Directed and random checks of seq_ripple_adder in the 32/8 and 8/8 configurations.
module tb_seq_ripple_adder;
  import seq_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 32/8 ----------------
  logic        iv32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir32, ov32, co32, ovf32, z32;
  logic [31:0] sum32;
  state_t      st32;

  seq_ripple_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
    .cout(co32), .ovf(ovf32), .zero(z32), .dbg_state(st32)
  );

  // ---------------- DUT 8/8 ----------------
  logic        iv8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, co8, ovf8, z8;
  logic [7:0]  sum8;
  state_t      st8;

  seq_ripple_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(co8), .ovf(ovf8), .zero(z8), .dbg_state(st8)
  );

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];
  logic [10:0] exp8_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic c,
                      input logic s, input int hold, input logic poke,
                      output logic [34:0] got, output int lat);
    logic [31:0] be;
    logic [32:0] full;
    int n;
    be   = s ? ~bv : bv;
    full = {1'b0, av} + {1'b0, be} + {32'd0, (s | c)};
    exp_q.push_back({full[32], (av[31] == be[31]) && (full[31] != av[31]),
                     (full[31:0] == 32'd0), full[31:0]});
    @(negedge clk);
    a32 = av; b32 = bv; cin32 = c; sub32 = s; iv32 = 1'b1; or32 = 1'b0;
    n = 0;
    while (!ir32 && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready32", ir32, 1);
    @(posedge clk);
    @(negedge clk);
    iv32 = poke;
    if (poke) begin a32 = $urandom; b32 = $urandom; cin32 = ~c; sub32 = ~s; end
    chk("run_flags32", {ir32, ov32}, 2'b00);
    lat = 0;
    while (!ov32 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    chk("out_valid32", ov32, 1);
    got = {co32, ovf32, z32, sum32};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_stable32", {co32, ovf32, z32, sum32}, got);
      chk("hold_hs32", {ir32, ov32}, 2'b01);
    end
    or32 = 1'b1;
    @(posedge clk); @(negedge clk);
    or32 = 1'b0; iv32 = 1'b0;
    chk("exit_hs32", {ir32, ov32}, 2'b10);
    chk("exit_keep32", {co32, ovf32, z32, sum32}, got);
    chk("scoreboard32", got, exp_q.pop_front());
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic c,
                     input logic s, input int hold,
                     output logic [10:0] got, output int lat);
    logic [7:0] be;
    logic [8:0] full;
    int n;
    be   = s ? ~bv : bv;
    full = {1'b0, av} + {1'b0, be} + {8'd0, (s | c)};
    exp8_q.push_back({full[8], (av[7] == be[7]) && (full[7] != av[7]),
                      (full[7:0] == 8'd0), full[7:0]});
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = c; sub8 = s; iv8 = 1'b1; or8 = 1'b0;
    n = 0;
    while (!ir8 && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready8", ir8, 1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    chk("run_flags8", {ir8, ov8}, 2'b00);
    lat = 0;
    while (!ov8 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    chk("out_valid8", ov8, 1);
    got = {co8, ovf8, z8, sum8};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_stable8", {co8, ovf8, z8, sum8}, got);
    end
    or8 = 1'b1;
    @(posedge clk); @(negedge clk);
    or8 = 1'b0;
    chk("exit_hs8", {ir8, ov8}, 2'b10);
    chk("scoreboard8", got, exp8_q.pop_front());
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [34:0] g32;
    logic [10:0] g8;
    int          lat;
    bit          seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state32", {st32, ir32, ov32, co32, ovf32, z32, sum32}, {IDLE, 2'b10, 3'b000, 32'd0});
    chk("reset_state8", {st8, ir8, ov8, co8, ovf8, z8, sum8}, {IDLE, 2'b10, 3'b000, 8'd0});
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_hs32", {ir32, ov32}, 2'b10);

    // all-ones plus one wraps to zero with carry out
    op32(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0, g32, lat);
    chk("wrap_sum", g32[31:0], 32'h00000000);
    chk("wrap_flags", g32[34:32], 3'b101);
    chk("wrap_latency", lat, 4);

    // 5 - 7 borrows
    op32(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1, 1'b0, g32, lat);
    chk("sub_sum", g32[31:0], 32'hFFFFFFFE);
    chk("sub_flags", g32[34:32], 3'b000);

    // signed overflow, then an add with carry-in
    op32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0, g32, lat);
    chk("ovf_sum", g32[31:0], 32'h80000000);
    chk("ovf_flags", g32[34:32], 3'b010);
    op32(32'h12345678, 32'h11111111, 1'b1, 1'b0, 0, 1'b0, g32, lat);
    chk("cin_sum", g32[31:0], 32'h2345678A);

    // backpressure with new operands offered throughout RUN and HOLD
    op32(32'h0000F000, 32'h00001000, 1'b0, 1'b0, 5, 1'b1, g32, lat);
    chk("bp_sum", g32[31:0], 32'h00010000);
    chk("bp_flags", g32[34:32], 3'b000);

    // reset during the second RUN cycle aborts the transaction
    @(negedge clk);
    a32 = 32'h01010101; b32 = 32'h02020202; cin32 = 1'b0; sub32 = 1'b0; iv32 = 1'b1;
    @(posedge clk); @(negedge clk);
    iv32 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_in_run", st32, RUN);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {st32, ir32, ov32}, {IDLE, 2'b10});
    chk("abort_clear", {co32, ovf32, z32, sum32}, 35'd0);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (ov32) seen = 1'b1; end
    chk("abort_no_result", seen, 1'b0);

    // single-chunk configuration
    op8(8'd200, 8'd100, 1'b1, 1'b0, 0, g8, lat);
    chk("w8_sum", g8[7:0], 8'd45);
    chk("w8_cout", g8[10], 1'b1);
    chk("w8_latency", lat, 1);
    op8(8'd16, 8'd16, 1'b0, 1'b1, 2, g8, lat);
    chk("w8_sub_zero", g8, {3'b101, 8'd0});

    for (int i = 0; i < 1000; i++) begin
      op32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2), 1'($urandom_range(0, 1)), g32, lat);
      if (lat != 4) chk("rand_latency32", lat, 4);
    end
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 2), g8, lat);
      if (lat != 1) chk("rand_latency8", lat, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_ripple_adder.md
SEQ_RIPPLE_ADDER -- requirements
Module: seq_ripple_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per cycle; WIDTH SHALL be a multiple of CHUNK and CHUNK >= 1, otherwise elaboration SHALL fail with a fatal error; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  operand transaction offered.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 cin  in  1  carry-in for add; ignored for subtract.
REQ-010 sub  in  1  0 = add (a+b+cin), 1 = subtract (a-b).
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer takes result.
REQ-013 sum  out  WIDTH  result.
REQ-014 cout  out  1  carry out of MSB (subtract: 1 = no borrow).
REQ-015 ovf  out  1  signed two's-complement overflow.
REQ-016 zero  out  1  sum == 0.

Function
REQ-017 FSM states IDLE, RUN, HOLD; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in HOLD.
REQ-018 IDLE: on in_valid && in_ready, latch a, b_eff = sub ? ~b : b, and carry = sub ? 1 : cin; clear chunk index to 0; go to RUN.
REQ-019 RUN: each cycle add chunk k of a and b_eff with the registered carry, write sum[k*CHUNK +: CHUNK], register the chunk carry-out, increment k.
REQ-020 RUN -> HOLD after the chunk with k == NCHUNK-1; out_valid SHALL rise exactly NCHUNK cycles after the accept edge.
REQ-021 In HOLD: cout = final carry; ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]); zero = (sum == 0).
REQ-022 HOLD: sum, cout, ovf and zero SHALL stay stable while out_ready == 0; on out_ready go to IDLE next cycle.
REQ-023 Only one transaction is in flight; in_valid outside IDLE SHALL be ignored and SHALL not alter latched operands.
REQ-024 Minimum throughput: one result per NCHUNK+2 cycles; no accept in the HOLD-exit cycle.
REQ-025 CHUNK == WIDTH SHALL be legal and give a RUN phase of one cycle.
REQ-026 Arithmetic is modulo 2^WIDTH; no saturation.
REQ-027 sum and flags outside HOLD SHALL hold their last values; they are not meaningful there.

Reset
REQ-028 While rst is high at a clock edge: state <= IDLE, chunk index <= 0, sum <= 0, cout/ovf/zero <= 0, internal carry <= 0.
REQ-029 After reset, out_valid = 0 and in_ready = 1.
REQ-030 rst asserted in RUN or HOLD SHALL abort the transaction with no result; behaviour is the same as REQ-028.
REQ-031 rst takes priority over in_valid and out_ready in the same cycle.

Structure
REQ-032 Package seq_adder_pkg SHALL hold the state typedef enum (IDLE, RUN, HOLD).
REQ-033 Sub-module chunk_adder: combinational CHUNK-bit ripple adder (a, b, cin -> sum, cout) built from full-adder cells, instantiated once.
REQ-034 Chunk index width SHALL be $clog2(NCHUNK), minimum 1.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-035 add 0xFFFFFFFF + 0x00000001, cin=0 -> sum 0x00000000, cout 1, zero 1, ovf 0; out_valid 4 cycles after accept.
REQ-036 sub 0x00000005 - 0x00000007 -> sum 0xFFFFFFFE, cout 0, ovf 0, zero 0.
REQ-037 add 0x7FFFFFFF + 0x00000001, cin=0 -> sum 0x80000000, ovf 1, cout 0; also 0x12345678 + 0x11111111, cin=1 -> 0x2345678A.
REQ-038 Backpressure: out_ready = 0 for 5 cycles in HOLD, in_valid = 1 with new operands -> outputs stable, in_ready 0, the new operands are not taken; the first result is delivered when out_ready rises.
REQ-039 rst pulse during the 2nd RUN cycle -> next cycle IDLE, in_ready 1, out_valid 0, sum 0; no result is emitted.
REQ-040 WIDTH=8, CHUNK=8: 8'd200 + 8'd100, cin=1 -> sum 8'd45, cout 1; out_valid 1 cycle after accept. Random 1000 ops in both configs checked against a reference model.
